// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: response owner encoding
// and default memory-map parameters.
package sram_port_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam logic [31:0] MEM_BASE_DEF   = 32'h0;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_addr_check.sv
// Byte-address qualifier for one requester: flags misaligned or out-of-region
// addresses and maps the byte address onto an SRAM word address.
module sram_addr_check
    import sram_port_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF
) (
    input  logic [31:0]           addr,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] word_addr
);

    assign fault     = (addr[1:0] != 2'b00) ||
                       (addr[31:ADDR_WIDTH+2] != MEM_BASE[31:ADDR_WIDTH+2]);
    assign word_addr = addr[ADDR_WIDTH+1:2];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single 1RW SRAM port between the fetch (I) and load/store (D)
// requesters: D-priority arbitration with an I starvation guard, 1-cycle response.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int          DATA_WIDTH   = 32,
    parameter int          NUM_WMASKS   = 4,
    parameter logic [31:0] MEM_BASE     = MEM_BASE_DEF,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [31:0]           i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_err,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [NUM_WMASKS-1:0] d_req_wmask,
    input  logic [31:0]           d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_rdata,
    output logic                  d_resp_err,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                  i_fault, d_fault;
    logic [ADDR_WIDTH-1:0] i_word, d_word;
    logic                  grant_i, grant_d;
    logic [CNT_W-1:0]      starve_cnt;
    owner_e                resp_owner;
    logic                  resp_err, resp_we;
    logic                  resp_rd_ok;

    sram_addr_check #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE)) u_i_check (
        .addr      (i_req_addr),
        .fault     (i_fault),
        .word_addr (i_word)
    );

    sram_addr_check #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE)) u_d_check (
        .addr      (d_req_addr),
        .fault     (d_fault),
        .word_addr (d_word)
    );

    // D wins unless I has already lost STARVE_LIMIT consecutive cycles.
    assign grant_d     = d_req_valid && !(i_req_valid && (starve_cnt == STARVE_MAX));
    assign grant_i     = i_req_valid && !grant_d;
    assign d_req_ready = grant_d;
    assign i_req_ready = grant_i;

    // NOTE: every output gets its idle value before any branch, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (grant_d && !d_fault) begin
            sram_csb   = 1'b0;
            sram_web   = ~d_req_we;
            sram_wmask = d_req_wmask;
            sram_addr  = d_word;
            sram_din   = d_req_wdata;
        end else if (grant_i && !i_fault) begin
            sram_csb  = 1'b0;
            sram_addr = i_word;
            sram_din  = d_req_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (i_req_valid && !grant_i) begin
            if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_owner <= OWN_NONE;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
        end else if (grant_d) begin
            resp_owner <= OWN_D;
            resp_err   <= d_fault;
            resp_we    <= d_req_we;
        end else if (grant_i) begin
            resp_owner <= OWN_I;
            resp_err   <= i_fault;
            resp_we    <= 1'b0;
        end else begin
            resp_owner <= OWN_NONE;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
        end
    end

    // Faulted accesses and stores never read the SRAM, so their data is forced to 0.
    assign resp_rd_ok   = !resp_err && !resp_we;
    assign i_resp_valid = (resp_owner == OWN_I);
    assign i_resp_err   = i_resp_valid && resp_err;
    assign i_resp_data  = (i_resp_valid && resp_rd_ok) ? sram_dout : '0;
    assign d_resp_valid = (resp_owner == OWN_D);
    assign d_resp_err   = d_resp_valid && resp_err;
    assign d_resp_rdata = (d_resp_valid && resp_rd_ok) ? sram_dout : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: directed scenarios plus randomized
// traffic, checked against a word-level memory and arbitration model.
module tb_sram_port_arbiter;

    localparam int AW    = 12;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_err;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_err;
    logic [3:0]  d_req_wmask, sram_wmask;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
    logic        sram_csb, sram_web;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4),
        .MEM_BASE(32'h0), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_wmask(d_req_wmask), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    typedef struct {
        int          owner;   // 1 = I, 2 = D
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        i_acc = 1'b0;
    logic        d_acc = 1'b0;
    logic [31:0] sram_mem [4096];
    logic [31:0] ref_mem  [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h0;
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic logic faulty(logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h4000);
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r = $urandom_range(0, 15);
        logic [31:0] w = $urandom_range(0, 31) * 4;
        if (r == 0) return w + $urandom_range(1, 3);
        if (r == 1) return 32'h4000 + w;
        if (r == 2) return $urandom | 32'h8000_0000;
        return w;
    endfunction

    task automatic check_idle(string tag);
        check({tag, "_csb"},   sram_csb, 1);
        check({tag, "_web"},   sram_web, 1);
        check({tag, "_wmask"}, sram_wmask, 0);
        check({tag, "_addr"},  sram_addr, 0);
        check({tag, "_din"},   sram_din, 0);
    endtask

    // Behavioural SRAM: one access per cycle, read data appears after the edge.
    initial begin
        for (int i = 0; i < 4096; i++) sram_mem[i] = init_word(i);
        sram_dout = '0;
        forever begin
            @(posedge clk);
            if (!sram_csb) begin
                if (!sram_web) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
                end else begin
                    sram_dout = sram_mem[sram_addr];
                end
            end
        end
    end

    // Reference model: decides the winner from the arbitration rules and
    // predicts the SRAM drive and the response that must follow.
    initial begin
        int   starve_m = 0;
        logic gd, gi, st;
        logic [31:0] a;
        int   idx;
        exp_t e;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                starve_m = 0;
                i_acc = 1'b0;
                d_acc = 1'b0;
            end else begin
                gd = d_req_valid && !(i_req_valid && starve_m == LIMIT);
                gi = i_req_valid && !gd;
                check("i_req_ready", i_req_ready, gi);
                check("d_req_ready", d_req_ready, gd);
                if (gd || gi) begin
                    a       = gd ? d_req_addr : i_req_addr;
                    st      = gd && d_req_we;
                    e.owner = gd ? 2 : 1;
                    e.err   = faulty(a);
                    e.due   = cyc + 1;
                    idx     = a / 4;
                    e.data  = (e.err || st) ? 32'h0 : ref_mem[idx];
                    if (e.err) begin
                        check_idle("fault_sram");
                    end else begin
                        check("sram_csb", sram_csb, 0);
                        check("sram_web", sram_web, !st);
                        check("sram_addr", sram_addr, idx);
                        check("sram_wmask", sram_wmask, gd ? d_req_wmask : 4'h0);
                        if (gd) check("sram_din", sram_din, d_req_wdata);
                        if (st)
                            for (int b = 0; b < 4; b++)
                                if (d_req_wmask[b]) ref_mem[idx][8*b +: 8] = d_req_wdata[8*b +: 8];
                    end
                    sb.push_back(e);
                end else begin
                    check_idle("idle_sram");
                end
                starve_m = (i_req_valid && !gi) ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
                i_acc = gi;
                d_acc = gd;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                check("rst_resp_valid", {i_resp_valid, d_resp_valid, i_resp_err, d_resp_err}, 0);
                check("rst_i_data", i_resp_data, 0);
                check("rst_d_data", d_resp_rdata, 0);
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("i_resp_valid", i_resp_valid, e.owner == 1);
                check("d_resp_valid", d_resp_valid, e.owner == 2);
                if (e.owner == 1) begin
                    check("i_resp_err", i_resp_err, e.err);
                    check("i_resp_data", i_resp_data, e.data);
                end else begin
                    check("d_resp_err", d_resp_err, e.err);
                    check("d_resp_rdata", d_resp_rdata, e.data);
                end
            end else begin
                check("spurious_resp", {i_resp_valid, d_resp_valid}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (i_acc) i_req_valid = 1'b0;
        if (d_acc) d_req_valid = 1'b0;
    endtask

    task automatic wait_d();
        for (int n = 0; n < 20 && d_req_valid; n++) tick();
        check("d_accept_bound", d_req_valid, 0);
        d_req_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] i_grants;
        reset       = 1'b1;
        i_req_valid = 1'b0; i_req_addr  = '0;
        d_req_valid = 1'b0; d_req_we    = 1'b0; d_req_wmask = '0;
        d_req_addr  = '0;   d_req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_sram");
        check("reset_starve", dut.starve_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fetch of word 4 on its own.
        i_req_addr = 32'h10; i_req_valid = 1'b1;
        @(negedge clk);
        check("t1_i_ready", i_req_ready, 1);
        check("t1_sram_addr", sram_addr, 4);
        check("t1_csb", sram_csb, 0);
        check("t1_web", sram_web, 1);
        tick();
        @(negedge clk);
        check("t1_resp_valid", i_resp_valid, 1);
        check("t1_resp_data", i_resp_data, 32'hDEADBEEF);
        tick();

        // Masked store then load of the same word.
        d_req_we = 1'b1; d_req_wmask = 4'b0011; d_req_addr = 32'h20;
        d_req_wdata = 32'h12345678; d_req_valid = 1'b1;
        wait_d();
        d_req_we = 1'b0; d_req_wmask = 4'b0000; d_req_valid = 1'b1;
        wait_d();
        @(negedge clk);
        check("t2_load_valid", d_resp_valid, 1);
        check("t2_load_data", d_resp_rdata, 32'h00005678);
        repeat (2) tick();

        // Starvation guard with both requesters always valid.
        i_req_addr = 32'h8; d_req_addr = 32'h4; d_req_we = 1'b0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        i_grants = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            i_grants[k] = i_req_ready;
            tick();
            i_req_valid = 1'b1;
            d_req_valid = 1'b1;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        check("t3_i_grant_cycles", i_grants, 12'h210);
        repeat (2) tick();

        // Misaligned then out-of-range loads.
        d_req_we = 1'b0; d_req_addr = 32'h4002; d_req_valid = 1'b1;
        @(negedge clk);
        check("t4_csb_misaligned", sram_csb, 1);
        tick();
        d_req_addr = 32'h4000; d_req_valid = 1'b1;
        @(negedge clk);
        check("t4_err_misaligned", d_resp_err, 1);
        check("t4_rdata_misaligned", d_resp_rdata, 0);
        check("t4_csb_range", sram_csb, 1);
        tick();
        @(negedge clk);
        check("t4_err_range", d_resp_err, 1);
        check("t4_rdata_range", d_resp_rdata, 0);
        tick();

        // Reset right after an accepted fetch drops its response.
        i_req_addr = 32'h10; i_req_valid = 1'b1;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_resp_in_reset", i_resp_valid, 0);
        check("t5_csb_in_reset", sram_csb, 1);
        check("t5_starve_in_reset", dut.starve_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_resp_after_reset", i_resp_valid, 0);
        tick();

        // Randomized traffic.
        repeat (400) begin
            if (!i_req_valid && $urandom_range(0, 2) != 0) begin
                i_req_addr  = rand_addr();
                i_req_valid = 1'b1;
            end
            if (!d_req_valid && $urandom_range(0, 2) != 0) begin
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_wmask = 4'($urandom);
                d_req_addr  = rand_addr();
                d_req_wdata = $urandom;
                d_req_valid = 1'b1;
            end
            tick();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) tick();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
